draw_control: RTL and testbench

DRAW_CONTROL -- requirements
Module: draw_control

---
 rtl/draw_control.sv | 178 +++++++++++++++++
 tb/tb_draw_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/draw_control.sv
// Draw sequencer: walks a sprite- or screen-sized raster one pixel per cycle,
// strobing the origin, x/y counter and ROM address counter controls.
module draw_control #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int SPRITE_W = 40,
   parameter int SPRITE_H = 40
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       abort,
   input  logic       isSprite,
   input  logic [4:0] memSelIn,
   input  logic [4:0] xSelIn,
   input  logic [1:0] ySelIn,
   output logic [4:0] memorySel,
   output logic [4:0] xInitSel,
   output logic [1:0] yInitSel,
   output logic       xInitLoad,
   output logic       yInitLoad,
   output logic       xLoad,
   output logic       yLoad,
   output logic       xCountUp,
   output logic       yCountUp,
   output logic       addressScreenCounterReset,
   output logic       addressSpriteCounterReset,
   output logic       screenCountLoad,
   output logic       spriteCountLoad,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_INIT = 3'd1,
      LOAD_XY   = 3'd2,
      PRIME     = 3'd3,
      DRAW      = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam logic [7:0] SPR_COL_LAST = 8'(SPRITE_W - 1);
   localparam logic [7:0] SCR_COL_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] SPR_ROW_LAST = 7'(SPRITE_H - 1);
   localparam logic [6:0] SCR_ROW_LAST = 7'(SCREEN_H - 1);

   state_t     state_q, state_d;
   logic [7:0] col_q, col_d;
   logic [6:0] row_q, row_d;
   logic       mode_q, mode_d;
   logic [4:0] mem_sel_q, mem_sel_d;
   logic [4:0] x_sel_q, x_sel_d;
   logic [1:0] y_sel_q, y_sel_d;

   logic [7:0] col_last;
   logic [6:0] row_last;
   logic       col_end, row_end;

   // Raster limits follow the mode latched at start, not the live isSprite pin.
   assign col_last = mode_q ? SPR_COL_LAST : SCR_COL_LAST;
   assign row_last = mode_q ? SPR_ROW_LAST : SCR_ROW_LAST;
   assign col_end  = (col_q == col_last);
   assign row_end  = (row_q == row_last);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      mode_d    = mode_q;
      mem_sel_d = mem_sel_q;
      x_sel_d   = x_sel_q;
      y_sel_d   = y_sel_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               mode_d    = isSprite;
               mem_sel_d = memSelIn;
               x_sel_d   = xSelIn;
               y_sel_d   = ySelIn;
               state_d   = LOAD_INIT;
            end
         end
         LOAD_INIT: state_d = LOAD_XY;
         LOAD_XY: begin
            col_d   = '0;
            row_d   = '0;
            state_d = PRIME;
         end
         PRIME: state_d = DRAW;
         DRAW: begin
            if (!col_end) begin
               col_d = col_q + 8'd1;
            end else if (!row_end) begin
               col_d = '0;
               row_d = row_q + 7'd1;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort outranks every transition; IDLE handles its own abort above.
      if (abort && state_q != IDLE) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         mode_q    <= 1'b0;
         mem_sel_q <= '0;
         x_sel_q   <= '0;
         y_sel_q   <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         mode_q    <= mode_d;
         mem_sel_q <= mem_sel_d;
         x_sel_q   <= x_sel_d;
         y_sel_q   <= y_sel_d;
      end
   end

   assign memorySel = mem_sel_q;
   assign xInitSel  = x_sel_q;
   assign yInitSel  = y_sel_q;

   always_comb begin
      xInitLoad                 = 1'b0;
      yInitLoad                 = 1'b0;
      xLoad                     = 1'b0;
      yLoad                     = 1'b0;
      xCountUp                  = 1'b0;
      yCountUp                  = 1'b0;
      addressScreenCounterReset = 1'b0;
      addressSpriteCounterReset = 1'b0;
      screenCountLoad           = 1'b0;
      spriteCountLoad           = 1'b0;
      plot                      = 1'b0;
      busy                      = (state_q != IDLE);
      done                      = 1'b0;
      case (state_q)
         LOAD_INIT: begin
            xInitLoad                 = 1'b1;
            yInitLoad                 = 1'b1;
            addressSpriteCounterReset = mode_q;
            addressScreenCounterReset = !mode_q;
         end
         LOAD_XY: begin
            xLoad = 1'b1;
            yLoad = 1'b1;
         end
         PRIME: begin
            spriteCountLoad = mode_q;
            screenCountLoad = !mode_q;
         end
         DRAW: begin
            plot            = 1'b1;
            spriteCountLoad = mode_q;
            screenCountLoad = !mode_q;
            if (!col_end) begin
               xCountUp = 1'b1;
            end else if (!row_end) begin
               xLoad    = 1'b1;
               yCountUp = 1'b1;
            end
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_draw_control.sv
// Directed bench for draw_control: sprite/screen rasters, abort, ignored start,
// async reset mid-draw and back-to-back draws with start held high.
module tb_draw_control;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start, abort, isSprite;
   logic [4:0] memSelIn, xSelIn;
   logic [1:0] ySelIn;
   logic [4:0] memorySel, xInitSel;
   logic [1:0] yInitSel;
   logic       xInitLoad, yInitLoad, xLoad, yLoad, xCountUp, yCountUp;
   logic       addressScreenCounterReset, addressSpriteCounterReset;
   logic       screenCountLoad, spriteCountLoad, plot, busy, done;

   int checks = 0;
   int errors = 0;

   int n_plot, n_xcu, n_pair, n_ycu, n_both, n_scl, first_plot, done_cyc;
   logic c1_scr, c1_spr, c1_busy, c1_xil;

   always #5 clk = ~clk;

   draw_control dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort), .isSprite(isSprite),
      .memSelIn(memSelIn), .xSelIn(xSelIn), .ySelIn(ySelIn),
      .memorySel(memorySel), .xInitSel(xInitSel), .yInitSel(yInitSel),
      .xInitLoad(xInitLoad), .yInitLoad(yInitLoad), .xLoad(xLoad), .yLoad(yLoad),
      .xCountUp(xCountUp), .yCountUp(yCountUp),
      .addressScreenCounterReset(addressScreenCounterReset),
      .addressSpriteCounterReset(addressSpriteCounterReset),
      .screenCountLoad(screenCountLoad), .spriteCountLoad(spriteCountLoad),
      .plot(plot), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE; that cycle is cycle 0.
   task automatic run_draw(input bit spr, input logic [4:0] m, input logic [4:0] x,
                           input logic [1:0] y, input bit keep, input int abort_at,
                           input int inject_at, input int reset_at);
      n_plot = 0; n_xcu = 0; n_pair = 0; n_ycu = 0; n_both = 0; n_scl = 0;
      first_plot = 0; done_cyc = 0;
      start = 1'b1; isSprite = spr; memSelIn = m; xSelIn = x; ySelIn = y;
      for (int cyc = 1; cyc <= 20000; cyc++) begin
         @(negedge clk);
         if (!keep) start = 1'b0;
         if (cyc == 1) begin
            c1_scr = addressScreenCounterReset; c1_spr = addressSpriteCounterReset;
            c1_busy = busy; c1_xil = xInitLoad;
         end
         if (plot) begin
            n_plot++;
            if (first_plot == 0) first_plot = cyc;
            if (xCountUp) n_xcu++;
            if (xLoad && yCountUp) n_pair++;
            if (xLoad && xCountUp) n_both++;
         end
         if (yCountUp) n_ycu++;
         if (spriteCountLoad) n_scl++;
         if (done) begin
            done_cyc = cyc;
            return;
         end
         if (inject_at != 0 && plot && n_plot == inject_at) begin
            start = 1'b1; isSprite = 1'b0; memSelIn = 5'd30; xSelIn = 5'd17; ySelIn = 2'd1;
         end
         if (abort_at != 0 && plot && n_plot == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_plot", plot, 0);
            chk("abort_done", done, 0);
            repeat (3) begin
               @(negedge clk);
               if (done) chk("abort_late_done", done, 0);
            end
            return;
         end
         if (reset_at != 0 && plot && n_plot == reset_at) begin
            #3 resetn = 1'b0;
            #1;
            chk("rst_plot", plot, 0);
            chk("rst_busy", busy, 0);
            chk("rst_xcu", xCountUp, 0);
            chk("rst_memsel", memorySel, 0);
            return;
         end
      end
      chk("timeout", 0, 1);
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; abort = 1'b0; isSprite = 1'b0;
      memSelIn = '0; xSelIn = '0; ySelIn = '0;
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_plot", plot, 0);
      chk("reset_done", done, 0);
      chk("reset_memsel", memorySel, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Sprite draw
      run_draw(1'b1, 5'd7, 5'd3, 2'd2, 1'b0, 0, 0, 0);
      chk("spr_done_cyc", done_cyc, 1604);
      chk("spr_first_plot", first_plot, 4);
      chk("spr_plots", n_plot, 1600);
      chk("spr_pairs", n_pair, 39);
      chk("spr_ycu", n_ycu, 39);
      chk("spr_xcu", n_xcu, 1560);
      chk("spr_both", n_both, 0);
      chk("spr_c1_rst", c1_spr, 1);
      chk("spr_c1_scr_rst", c1_scr, 0);
      chk("spr_c1_busy", c1_busy, 1);
      chk("spr_c1_xinit", c1_xil, 1);
      @(negedge clk);
      chk("spr_idle_busy", busy, 0);
      chk("spr_idle_done", done, 0);
      chk("spr_memsel", memorySel, 7);
      chk("spr_xsel", xInitSel, 3);
      chk("spr_ysel", yInitSel, 2);

      // Full-screen draw
      run_draw(1'b0, 5'd12, 5'd0, 2'd1, 1'b0, 0, 0, 0);
      chk("scr_done_cyc", done_cyc, 19204);
      chk("scr_plots", n_plot, 19200);
      chk("scr_ycu", n_ycu, 119);
      chk("scr_c1_rst", c1_scr, 1);
      chk("scr_c1_spr_rst", c1_spr, 0);
      chk("scr_spr_cl", n_scl, 0);
      @(negedge clk);
      chk("scr_memsel", memorySel, 12);

      // Abort at 500th plot, then a normal draw
      run_draw(1'b1, 5'd4, 5'd5, 2'd3, 1'b0, 500, 0, 0);
      chk("abort_plots", n_plot, 500);
      chk("abort_no_done", done_cyc, 0);
      run_draw(1'b1, 5'd4, 5'd5, 2'd3, 1'b0, 0, 0, 0);
      chk("post_abort_done", done_cyc, 1604);
      @(negedge clk);

      // Start pulsed mid-draw with other selects is ignored
      run_draw(1'b1, 5'd9, 5'd2, 2'd0, 1'b0, 0, 100, 0);
      chk("inj_plots", n_plot, 1600);
      chk("inj_done", done_cyc, 1604);
      chk("inj_memsel", memorySel, 9);
      chk("inj_xsel", xInitSel, 2);
      chk("inj_ysel", yInitSel, 0);
      @(negedge clk);

      // Async reset mid-draw
      run_draw(1'b1, 5'd6, 5'd1, 2'd1, 1'b0, 0, 0, 300);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      run_draw(1'b1, 5'd6, 5'd1, 2'd1, 1'b0, 0, 0, 0);
      chk("post_rst_done", done_cyc, 1604);
      chk("post_rst_plots", n_plot, 1600);
      @(negedge clk);

      // Start held high: one IDLE cycle between draws
      run_draw(1'b1, 5'd1, 5'd1, 2'd1, 1'b1, 0, 0, 0);
      chk("b2b_first_done", done_cyc, 1604);
      @(negedge clk);
      chk("b2b_gap_busy", busy, 0);
      chk("b2b_gap_done", done, 0);
      run_draw(1'b1, 5'd1, 5'd1, 2'd1, 1'b1, 0, 0, 0);
      chk("b2b_second_done", done_cyc, 1604);
      chk("b2b_second_c1_busy", c1_busy, 1);
      start = 1'b0;
      @(negedge clk);
      chk("b2b_end_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
